// File: rtl/rr_priority_encoder_pkg.sv
// rr_priority_encoder_pkg
// Shared types and helpers for the round-robin priority encoder.
//   mode_e          : arbitration mode encoding seen on the 'mode' input.
//   more_than_one() : true when two or more bits of a vector are set.
package rr_priority_encoder_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Clearing the lowest set bit leaves a non-zero value only if another
  // bit was set. Callers zero-extend request vectors of up to 64 bits.
  function automatic logic more_than_one(input logic [63:0] v);
    return |(v & (v - 64'd1));
  endfunction

endpackage

// File: rtl/rr_priority_encoder_find.sv
// prio_find_first
// Combinational lowest-set-bit finder.
//   vec   : input vector to search
//   found : at least one bit of vec is set
//   idx   : index of the lowest set bit (0 when nothing is set)
module prio_find_first #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    found = |vec;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
// N-to-log2(N) priority encoder with a registered output stage and a
// valid/ready handshake. Fixed priority (lowest index) or round-robin.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : level-sensitive request lines
//   mode      : 0 = fixed priority, 1 = round-robin
//   out_ready : consumer accepts the current output this cycle
//   out_valid : code/grant/multi hold a valid result
//   code      : binary index of the granted request
//   grant     : one-hot of the granted request (0 when not valid)
//   multi     : more than one request was set at capture
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] code,
  output logic [N-1:0] grant,
  output logic         multi
);

  logic [W-1:0]   ptr_r;
  logic [W-1:0]   search_base_s;
  logic [2*N-1:0] req_dbl_s;
  logic [N-1:0]   req_rot_s;
  logic           found_s;
  logic [W-1:0]   rot_idx_s;
  logic [W-1:0]   win_idx_s;
  logic           free_s;
  logic           load_s;
  logic           multi_s;

  // Rotate requests so the search base lands at bit 0; fixed mode searches
  // from index 0, round-robin from the pointer.
  always_comb begin
    if (mode == MODE_RR) begin
      search_base_s = ptr_r;
    end else begin
      search_base_s = {W{1'b0}};
    end
    req_dbl_s = {req, req} >> search_base_s;
    req_rot_s = req_dbl_s[N-1:0];
  end

  prio_find_first #(.N(N)) u_find (
    .vec   (req_rot_s),
    .found (found_s),
    .idx   (rot_idx_s)
  );

  // Undo the rotation; W-bit addition wraps modulo N because N is a power
  // of two.
  always_comb begin
    win_idx_s = rot_idx_s + search_base_s;
    free_s    = !out_valid || out_ready;
    load_s    = free_s && found_s;
    multi_s   = more_than_one(64'(req));
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code      <= {W{1'b0}};
      grant     <= {N{1'b0}};
      multi     <= 1'b0;
      ptr_r     <= {W{1'b0}};
    end else if (load_s) begin
      out_valid <= 1'b1;
      code      <= win_idx_s;
      grant     <= {{(N-1){1'b0}}, 1'b1} << win_idx_s;
      multi     <= multi_s;
      if (mode == MODE_RR) begin
        ptr_r <= win_idx_s + W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (free_s) begin
      // Transfer accepted with nothing new to offer: drop valid, keep
      // code/multi, clear grant so it stays zero while invalid.
      out_valid <= 1'b0;
      grant     <= {N{1'b0}};
    end else begin
      // Backpressure: hold everything.
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] code;
  logic [N-1:0] grant;
  logic         multi;

  rr_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .grant     (grant),
    .multi     (multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [N-1:0] grant;
    logic         multi;
  } result_t;

  result_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: what the encoder should be presenting / remembering.
  int   m_ptr = 0;
  logic m_valid = 1'b0;
  logic exp_valid_cur = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: walk upward from the start point with wraparound
  // and take the first asserted request.
  function automatic int ref_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Apply inputs for the coming edge and advance the reference model.
  task automatic apply(input logic [N-1:0] r, input logic m, input logic rdy);
    result_t e;
    int j;
    req = r;
    mode = m;
    out_ready = rdy;
    exp_valid_cur = m_valid;
    if (!m_valid || rdy) begin
      if (r != '0) begin
        j = ref_pick(r, m ? m_ptr : 0);
        e.idx = j;
        e.grant = '0;
        e.grant[j] = 1'b1;
        e.multi = ($countones(r) > 1);
        sb_q.push_back(e);
        m_valid = 1'b1;
        if (m) m_ptr = (j + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic m, input logic rdy);
    @(negedge clk);
    apply(r, m, rdy);
  endtask

  // Monitor: compare whenever a result is handed over (valid && ready).
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("out_valid", out_valid, exp_valid_cur);
        if (!out_valid) check("grant_idle", grant, 0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_empty: got transfer code %0d expected none", code);
          end else begin
            e = sb_q.pop_front();
            check("code", code, e.idx);
            check("grant", grant, e.grant);
            check("multi", multi, e.multi);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    // Reset held with all requests up and the clock running.
    req = 8'hFF;
    mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_code", code, 0);
      check("rst_grant", grant, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hFF, 1'b0, 1'b1);           // first edge -> code 0
    drive(8'b0010_1100, 1'b0, 1'b1);    // code 2, multi
    drive(8'h80, 1'b0, 1'b1);           // code 7, single
    // Backpressure: capture code 2, then stall with a changed request.
    drive(8'b0010_1100, 1'b0, 1'b1);
    repeat (3) drive(8'h80, 1'b0, 1'b0);
    drive(8'h80, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    // Round-robin fairness from ptr 0.
    repeat (10) drive(8'hFF, 1'b1, 1'b1);
    // Wrap/skip: grant 4 to put ptr at 5, then 06 -> 1, 2; then 01 -> 0.
    drive(8'h10, 1'b1, 1'b1);
    drive(8'b0000_0110, 1'b1, 1'b1);
    drive(8'b0000_0110, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b1);           // ptr 1, request 0 still wins
    // Reset mid-hold: grant 5 (ptr 6), stall, pulse reset between edges.
    drive(8'h20, 1'b1, 1'b1);
    drive(8'h20, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_code", code, 0);
    check("midrst_grant", grant, 0);
    check("midrst_multi", multi, 0);
    sb_q.delete();
    m_ptr = 0;
    m_valid = 1'b0;
    exp_valid_cur = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(8'hFF, 1'b1, 1'b1);           // fresh start -> code 0
    drive(8'hFF, 1'b1, 1'b1);
    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 8'(1) << $urandom_range(0, N - 1);
        default: r = 8'($urandom);
      endcase
      drive(r, 1'($urandom), ($urandom_range(0, 9) < 7));
    end
    // Drain.
    repeat (3) drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
